// File: rtl/md_sequencer_if.sv
// Handshake/bus bundle between the E-stage decode and the multiply/divide sequencer.
// The master side drives decoded controls and operands; the slave side is the sequencer.
interface md_sequencer_if;
  logic [1:0]  md_cal;
  logic        is_signed;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [1:0]  other_reg_wr;
  logic [1:0]  md_read;
  logic        d_md_use;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_cal, is_signed, rs_data, rt_data, other_reg_wr, md_read, d_md_use, flush,
    input  busy, stall_req, md_rdata, hi, lo
  );

  modport slave (
    input  md_cal, is_signed, rs_data, rt_data, other_reg_wr, md_read, d_md_use, flush,
    output busy, stall_req, md_rdata, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; defining MD_MADD_EN adds MADD/MADDU on md_cal==11.
// Latency: busy for MULT_CYCLES/DIV_CYCLES cycles after the start edge, result visible the cycle after.
// Backpressure: no handshake; stall_req holds the D stage while an op is starting or in flight.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, res_cnt;
  logic [31:0]      hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic             pend_wr_q, res_wr;
  logic             is_op, start, commit, move_ok;
  logic [63:0]      op_a, op_b, product, res;
  logic             rs_neg, rt_neg;
  logic [31:0]      abs_a, abs_b, den, q_mag, r_mag, quo, rem;

`ifdef MD_MADD_EN
  assign is_op = (md.md_cal != 2'b00);
`else
  assign is_op = (md.md_cal == 2'b01) || (md.md_cal == 2'b10);
`endif
  assign start   = is_op && !md.flush && (state_q == IDLE);
  assign commit  = (state_q == BUSY) && (cnt_q == '0);
  assign move_ok = (state_q == IDLE) && !md.flush;

  // Sign/zero extension to 64 bits lets one multiplier serve both signed and unsigned forms.
  assign op_a    = {{32{md.is_signed & md.rs_data[31]}}, md.rs_data};
  assign op_b    = {{32{md.is_signed & md.rt_data[31]}}, md.rt_data};
  assign product = op_a * op_b;

  assign rs_neg = md.is_signed & md.rs_data[31];
  assign rt_neg = md.is_signed & md.rt_data[31];
  assign abs_a  = rs_neg ? (~md.rs_data + 32'd1) : md.rs_data;
  assign abs_b  = rt_neg ? (~md.rt_data + 32'd1) : md.rt_data;
  assign den    = (abs_b == '0) ? 32'd1 : abs_b;
  assign q_mag  = abs_a / den;
  assign r_mag  = abs_a % den;
  assign quo    = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = rs_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res     = product;
    res_wr  = 1'b1;
    res_cnt = CNT_W'(MULT_CYCLES - 1);
    if (md.md_cal == 2'b10) begin
      res     = {rem, quo};
      res_wr  = |md.rt_data;
      res_cnt = CNT_W'(DIV_CYCLES - 1);
    end
`ifdef MD_MADD_EN
    else if (md.md_cal == 2'b11) begin
      res = {hi_q, lo_q} + product;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = res_cnt;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      if (start) begin
        pend_hi_q <= res[63:32];
        pend_lo_q <= res[31:0];
        pend_wr_q <= res_wr;
      end
      // A divide by zero keeps HI/LO untouched but still runs its full busy window.
      if (commit) begin
        if (pend_wr_q) begin
          hi_q <= pend_hi_q;
          lo_q <= pend_lo_q;
        end
      end else if (move_ok) begin
        if (md.other_reg_wr == 2'b10) hi_q <= md.rs_data;
        if (md.other_reg_wr == 2'b01) lo_q <= md.rs_data;
      end
    end
  end

  always_comb begin
    md.md_rdata = '0;
    if (md.md_read == 2'b10)      md.md_rdata = hi_q;
    else if (md.md_read == 2'b01) md.md_rdata = lo_q;
  end

  assign md.busy      = (state_q == BUSY);
  assign md.stall_req = md.d_md_use & ((state_q == BUSY) | (is_op & !md.flush));
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
endmodule
